mul_div_unit: RTL and testbench

Multiply/divide unit in the EX stage of the pipelined MIPS core. It consumes the `Start` and `XAluOp` controls that the main controller decodes for mult/multu/div/divu/mthi/mtlo, and runs the multi-cycle operation. It owns the HI/LO registers and presents a read port for mfhi/mflo. `Busy` feeds the hazard unit, which stalls any following HI/LO instruction.

---
 rtl/mul_div_unit.sv | 111 +++++++++++
 tb/tb_mul_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, runs mult/multu/div/divu
// with fixed latencies, and services mthi/mtlo moves and the mfhi/mflo read port.
module mul_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Start,
    input  logic [2:0]  XAluOp,
    input  logic        Flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RdSel,
    output logic        Busy,
    output logic [31:0] HiLoOut,
    output logic        fsm_state
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    // Handshake: Start is a single-cycle request sampled only in IDLE with Flush low;
    // Busy is purely registered (state == RUN) and never reacts combinationally to Start.
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [1:0]       op_q;
    logic [31:0]      hi;
    logic [31:0]      lo;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    // Low 64 bits of the sign-extended product equal the two's-complement signed product.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division on magnitudes keeps 0x80000000 / -1 well defined (quotient wraps).
    assign a_neg   = ~op_q[0] & a_q[31];
    assign b_neg   = ~op_q[0] & b_q[31];
    assign mag_a   = a_neg ? (~a_q + 32'd1) : a_q;
    assign mag_b   = b_neg ? (~b_q + 32'd1) : b_q;
    assign divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign uq      = mag_a / divisor;
    assign ur      = mag_a % divisor;
    assign quo     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    assign rem     = a_neg ? (~ur + 32'd1) : ur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!Flush && Start == 2'b01 && !XAluOp[2]) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= XAluOp[1:0];
                        cnt   <= XAluOp[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                        state <= RUN;
                    end else if (!Flush && Start == 2'b10) begin
                        if (XAluOp == 3'b100) begin
                            hi <= A;
                        end else if (XAluOp == 3'b101) begin
                            lo <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        if (!op_q[1]) begin
                            {hi, lo} <= op_q[0] ? prod_u : prod_s;
                        end else if (b_q != 32'd0) begin
                            lo <= quo;
                            hi <= rem;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state == RUN);
    assign HiLoOut   = RdSel ? hi : lo;
    assign fsm_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, results, move-to, flush, back-to-back, abort.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  Start;
    logic [2:0]  XAluOp;
    logic        Flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        RdSel;
    logic        Busy;
    logic [31:0] HiLoOut;
    logic        fsm_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    mul_div_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk),
        .reset(reset),
        .Start(Start),
        .XAluOp(XAluOp),
        .Flush(Flush),
        .A(A),
        .B(B),
        .RdSel(RdSel),
        .Busy(Busy),
        .HiLoOut(HiLoOut),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        RdSel = 1'b1;
        #1;
        check({tag, " hi"}, HiLoOut, exp_hi);
        RdSel = 1'b0;
        #1;
        check({tag, " lo"}, HiLoOut, exp_lo);
    endtask

    // Called just after a negedge; returns just after the negedge following the launch edge.
    task automatic launch(input logic [1:0] st, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        Start  = st;
        XAluOp = op;
        A      = a;
        B      = b;
        @(negedge clk);
        Start  = 2'b00;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset  = 1'b0;
        Start  = 2'b01;
        XAluOp = 3'b000;
        Flush  = 1'b0;
        A      = 32'd3;
        B      = 32'd4;
        RdSel  = 1'b0;

        // Reset held across a mult launch request
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset state", {31'd0, fsm_state}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);
        Start = 2'b00;
        reset = 1'b1;
        @(negedge clk);

        // Signed mult -2 * 3
        launch(2'b01, 3'b000, 32'hFFFF_FFFE, 32'd3);
        check("mult busy on", {31'd0, Busy}, 32'd1);
        wait_idle(cyc);
        check("mult busy cycles", 32'(cyc), 32'd5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Unsigned mult of the same operands
        launch(2'b01, 3'b001, 32'hFFFF_FFFE, 32'd3);
        wait_idle(cyc);
        check("multu busy cycles", 32'(cyc), 32'd5);
        read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        // Signed div -7 / 2
        launch(2'b01, 3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        check("div busy cycles", 32'(cyc), 32'd10);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Unsigned div 7 / 2
        launch(2'b01, 3'b011, 32'd7, 32'd2);
        wait_idle(cyc);
        check("divu busy cycles", 32'(cyc), 32'd10);
        read_hilo("divu", 32'd1, 32'd3);

        // Divide by zero keeps HI/LO
        launch(2'b01, 3'b010, 32'd5, 32'd0);
        wait_idle(cyc);
        check("div0 busy cycles", 32'(cyc), 32'd10);
        read_hilo("div0", 32'd1, 32'd3);

        // Overflow case
        launch(2'b01, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        read_hilo("div ovf", 32'd0, 32'h8000_0000);

        // Move-to HI then LO
        launch(2'b10, 3'b100, 32'h1234_5678, 32'd0);
        check("mthi busy", {31'd0, Busy}, 32'd0);
        read_hilo("mthi", 32'h1234_5678, 32'h8000_0000);
        launch(2'b10, 3'b101, 32'hCAFE_F00D, 32'd0);
        read_hilo("mtlo", 32'h1234_5678, 32'hCAFE_F00D);

        // Invalid op code is a no-op
        launch(2'b01, 3'b110, 32'd1, 32'd1);
        check("invalid busy", {31'd0, Busy}, 32'd0);
        read_hilo("invalid", 32'h1234_5678, 32'hCAFE_F00D);

        // mtlo during a div is ignored; 100 / 7 = 14 r 2
        launch(2'b01, 3'b010, 32'd100, 32'd7);
        launch(2'b10, 3'b101, 32'hDEAD_BEEF, 32'd0);
        wait_idle(cyc);
        check("div+mtlo busy cycles", 32'(cyc), 32'd9);
        read_hilo("div+mtlo", 32'd2, 32'd14);

        // Flush blocks launch, then an unflushed mult 4 * 5
        Flush = 1'b1;
        launch(2'b01, 3'b000, 32'd9, 32'd9);
        Flush = 1'b0;
        check("flush busy", {31'd0, Busy}, 32'd0);
        read_hilo("flush", 32'd2, 32'd14);
        launch(2'b01, 3'b000, 32'd4, 32'd5);
        wait_idle(cyc);
        check("post-flush busy cycles", 32'(cyc), 32'd5);
        read_hilo("post-flush", 32'd0, 32'd20);

        // Back-to-back: mult 6 * 7 then divu 0xFFFFFFFF / 16 after one idle cycle
        launch(2'b01, 3'b000, 32'd6, 32'd7);
        wait_idle(cyc);
        check("b2b mult cycles", 32'(cyc), 32'd5);
        check("b2b gap", {31'd0, Busy}, 32'd0);
        read_hilo("b2b mult", 32'd0, 32'd42);
        launch(2'b01, 3'b011, 32'hFFFF_FFFF, 32'd16);
        check("b2b divu busy", {31'd0, Busy}, 32'd1);
        wait_idle(cyc);
        check("b2b divu cycles", 32'(cyc), 32'd10);
        read_hilo("b2b divu", 32'h0000_000F, 32'h0FFF_FFFF);

        // Abort: reset asserted in the third RUN cycle of a mult
        launch(2'b01, 3'b000, 32'd5, 32'd5);
        @(negedge clk);
        @(negedge clk);
        check("abort pre busy", {31'd0, Busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, Busy}, 32'd0);
        read_hilo("abort", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("abort later busy", {31'd0, Busy}, 32'd0);
        read_hilo("abort later", 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
